sram_emulator: RTL and testbench

Parametrised, cycle-accurate emulator of an asynchronous SRAM for the memory-emulation test platform. It samples active-low chip/output/write enables, latches the request, and holds it for a programmable number of wait states before committing a byte-masked write or registering read data. A one-cycle `ready` pulse marks completion. Software-visible latency is independent for reads and writes, so one block can stand in for stack, data and program memories of different speeds.

---
 rtl/sram_if.sv | 27 ++
 rtl/sram_emulator.sv | 143 ++++++++++++++
 tb/tb_sram_emulator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_if.sv
// SRAM emulator bus: active-low strobes and byte enables from the master,
// registered read data and status pulses back from the emulator.
interface sram_if #(
  parameter int WIDTH         = 32,
  parameter int RAM_ADDR_BITS = 10
);
  logic                     CE;
  logic                     OE;
  logic                     WE;
  logic [WIDTH/8-1:0]       BE;
  logic [RAM_ADDR_BITS-1:0] address;
  logic [WIDTH-1:0]         input_data;
  logic [WIDTH-1:0]         output_data;
  logic                     ready;
  logic                     busy;
  logic                     err;

  modport master (
    output CE, OE, WE, BE, address, input_data,
    input  output_data, ready, busy, err
  );

  modport slave (
    input  CE, OE, WE, BE, address, input_data,
    output output_data, ready, busy, err
  );
endinterface

// File: rtl/sram_emulator.sv
// Cycle-accurate asynchronous SRAM emulator with independent read/write
// wait states. One access per CE assertion; ready pulses on completion.
// Optional macro SRAM_EMU_CONFLICT_CHECK_EN: OE and WE both low at accept
// raises a one-cycle err and no access. Without it WE wins and err is 0.
//
// state | meaning
// IDLE  | waiting for CE low with a read or write strobe
// WAIT  | request latched, counting wait states
// DONE  | access finished, waiting for CE to be released
module sram_emulator #(
  parameter int WIDTH         = 32,
  parameter int RAM_ADDR_BITS = 10,
  parameter int READ_WAIT     = 5,
  parameter int WRITE_WAIT    = 5
) (
  input  logic  clk,
  input  logic  rst_n,
  sram_if.slave bus
);
  localparam int LANES = WIDTH / 8;
  localparam int DEPTH = 2 ** RAM_ADDR_BITS;
  localparam logic [7:0] RD_LAT = 8'(READ_WAIT);
  localparam logic [7:0] WR_LAT = 8'(WRITE_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                   state, state_nxt;
  logic [7:0]               cnt, cnt_nxt;
  logic                     op_wr_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]         din_q;
  logic [LANES-1:0]         be_q;
  logic [WIDTH-1:0]         dout_q;
  logic                     ready_q, ready_nxt;
  logic                     err_q, err_nxt;
  logic                     latch, rd_en, wr_en;
  logic                     req_any, conflict_hit;
  logic [7:0]               lat;

  logic [WIDTH-1:0]         mem [DEPTH];

`ifdef SRAM_EMU_CONFLICT_CHECK_EN
  assign req_any      = !bus.CE && (bus.OE != bus.WE);
  assign conflict_hit = !bus.CE && !bus.OE && !bus.WE;
`else
  // Both strobes low falls through as a write because op is taken from WE.
  assign req_any      = !bus.CE && (!bus.OE || !bus.WE);
  assign conflict_hit = 1'b0;
`endif

  assign lat = op_wr_q ? WR_LAT : RD_LAT;

  // Next-state, counter and completion strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    latch     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (conflict_hit) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (req_any) begin
          latch     = 1'b1;
          cnt_nxt   = 8'd1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.CE) begin
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (cnt == lat) begin
          rd_en     = !op_wr_q;
          wr_en     = op_wr_q;
          ready_nxt = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: begin
        if (bus.CE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= ready_nxt;
      err_q   <= err_nxt;
    end
  end

  // Request capture at accept; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '1;
    end else if (latch) begin
      op_wr_q <= !bus.WE;
      addr_q  <= bus.address;
      din_q   <= bus.input_data;
      be_q    <= bus.BE;
    end
  end

  // Read data register, updated only when a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else if (rd_en) dout_q <= mem[addr_q];
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (!be_q[i]) mem[addr_q][8*i +: 8] <= din_q[8*i +: 8];
      end
    end
  end

  assign bus.output_data = dout_q;
  assign bus.ready       = ready_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_sram_emulator.sv
// Directed bench for sram_emulator with READ_WAIT=5, WRITE_WAIT=3.
// Expected completions are queued at accept; a negedge monitor checks each
// ready pulse for its cycle and the output_data value.
module tb_sram_emulator;
  localparam int RW = 5;
  localparam int WW = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_rd = 32'h0;
  exp_t sb[$];

  sram_if #(.WIDTH(32), .RAM_ADDR_BITS(10)) bus ();

  sram_emulator #(
    .WIDTH(32), .RAM_ADDR_BITS(10), .READ_WAIT(RW), .WRITE_WAIT(WW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("output_data", bus.output_data, e.data);
        end
      end
    end
  end

  task automatic drive(input logic ce, input logic oe, input logic we,
                       input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.CE = ce; bus.OE = oe; bus.WE = we;
    bus.address = a; bus.input_data = d; bus.BE = be;
  endtask

  // Present a request at negedge, accept on the next posedge, optionally queue result.
  task automatic start(input logic oe, input logic we, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] rd_exp, input bit push);
    exp_t e;
    bit is_rd;
    is_rd = (!oe && we);
    @(negedge clk);
    drive(1'b0, oe, we, a, d, be);
    @(posedge clk);
    #1;
    if (push) begin
      if (is_rd) last_rd = rd_exp;
      e.data = last_rd;
      e.cyc  = cyc + (is_rd ? RW : WW);
      sb.push_back(e);
    end
  endtask

  // Wait for ready (scrambling latched inputs once), then release CE.
  task automatic finish();
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.OE = ~bus.OE; bus.WE = ~bus.WE;
        bus.address = bus.address ^ 10'h1;
        bus.input_data = ~bus.input_data; bus.BE = ~bus.BE;
      end
      if (bus.ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("ready_seen", 32'(got), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 10'h0, 32'h0, 4'hF);
    @(negedge clk);
    check("busy_release", 32'(bus.busy), 32'd0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    start(1'b1, 1'b0, a, d, be, 32'h0, 1'b1);
    finish();
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp);
    start(1'b0, 1'b1, a, 32'h0, 4'h0, exp, 1'b1);
    finish();
  endtask

  // Assert reset two cycles into WAIT; outputs must clear at once.
  task automatic reset_mid(input bit is_rd, input logic [9:0] a, input logic [31:0] d);
    start(is_rd ? 1'b0 : 1'b1, is_rd ? 1'b1 : 1'b0, a, d, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_output_data", bus.output_data, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 10'h0, 32'h0, 4'hF);
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_ready;
    int n_busy_low;
    drive(1'b1, 1'b1, 1'b1, 10'h0, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_output_data", bus.output_data, 32'h0);
    rst_n = 1'b1;

    wr(10'h010, 32'hDEADBEEF, 4'h0);
    rd(10'h010, 32'hDEADBEEF);

    wr(10'h3FF, 32'h11223344, 4'h0);
    wr(10'h3FF, 32'hAABBCCDD, 4'b1010);
    rd(10'h3FF, 32'h11BB33DD);

    wr(10'h010, 32'hFFFFFFFF, 4'hF);
    rd(10'h010, 32'hDEADBEEF);

    // Abort a write when the counter reads 2.
    wr(10'h020, 32'h12345678, 4'h0);
    start(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 10'h0, 32'h0, 4'hF);
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_output_data", bus.output_data, last_rd);
    repeat (4) @(negedge clk);
    rd(10'h020, 32'h12345678);

    // CE and OE held low for 20 cycles: one access only.
    start(1'b0, 1'b1, 10'h3FF, 32'h0, 4'h0, 32'h11BB33DD, 1'b1);
    n_ready = 0;
    n_busy_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) n_ready++;
      if (bus.busy !== 1'b1) n_busy_low++;
    end
    check("held_ready_count", 32'(n_ready), 32'd1);
    check("held_busy_low", 32'(n_busy_low), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 10'h0, 32'h0, 4'hF);
    @(negedge clk);
    check("held_busy_release", 32'(bus.busy), 32'd0);

    reset_mid(1'b1, 10'h020, 32'h0);
    reset_mid(1'b0, 10'h010, 32'h0BADF00D);
    rd(10'h010, 32'hDEADBEEF);
    rd(10'h3FF, 32'h11BB33DD);

    // CE, OE and WE all low.
`ifdef SRAM_EMU_CONFLICT_CHECK_EN
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 10'h020, 32'hCAFEF00D, 4'h0);
    @(negedge clk);
    check("conflict_err", 32'(bus.err), 32'd1);
    check("conflict_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("conflict_err_clear", 32'(bus.err), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 10'h0, 32'h0, 4'hF);
    @(negedge clk);
    check("conflict_busy_release", 32'(bus.busy), 32'd0);
    rd(10'h020, 32'h12345678);
`else
    start(1'b0, 1'b0, 10'h020, 32'hCAFEF00D, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("conflict_err_low", 32'(bus.err), 32'd0);
    finish();
    check("conflict_err_after", 32'(bus.err), 32'd0);
    rd(10'h020, 32'hCAFEF00D);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
